// File: rtl/pipe_sqrt_n_if.sv
// Streaming handshake bundle for pipe_sqrt_n: radicand/tag in, root/remainder/tag out.
interface pipe_sqrt_n_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned TAG_W = 4
) ();
    localparam int unsigned OUT_W = IN_W / 2;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_root;
    logic [OUT_W:0]   out_rem;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_root, out_rem, out_tag, busy
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_root, out_rem, out_tag, busy
    );
endinterface

// File: rtl/pipe_sqrt_n.sv
// Fully pipelined restoring integer square root, one root bit per stage, with a
// single global stall enable, remainder output, optional rounding and tag passthrough.
module pipe_sqrt_n #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ROUND = 0,
    parameter int unsigned TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_sqrt_n_if.slave bus
);
    localparam int unsigned OUT_W = IN_W / 2;
    localparam int unsigned REM_W = OUT_W + 2;

    logic [OUT_W-1:0] valid_q, valid_d;
    logic [OUT_W-1:0] root_q [OUT_W];
    logic [OUT_W-1:0] root_d [OUT_W];
    logic [REM_W-1:0] rem_q  [OUT_W];
    logic [REM_W-1:0] rem_d  [OUT_W];
    logic [IN_W-1:0]  rad_q  [OUT_W];
    logic [IN_W-1:0]  rad_d  [OUT_W];
    logic [TAG_W-1:0] tag_q  [OUT_W];
    logic [TAG_W-1:0] tag_d  [OUT_W];
    logic             en;

    assign en = ~valid_q[OUT_W-1] | bus.out_ready;

    always_comb begin
        logic [OUT_W-1:0] root_p, root_n;
        logic [REM_W-1:0] rem_p, rem_s, trial;
        logic [IN_W-1:0]  rad_p;
        logic [TAG_W-1:0] tag_p;
        logic             vld_p;
        int unsigned      km1;
        valid_d = '0;
        for (int k = 0; k < OUT_W; k++) begin
            km1 = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                root_p = '0;
                rem_p  = '0;
                rad_p  = bus.in_data;
                tag_p  = bus.in_tag;
                vld_p  = bus.in_valid;
            end else begin
                root_p = root_q[km1];
                rem_p  = rem_q[km1];
                rad_p  = rad_q[km1];
                tag_p  = tag_q[km1];
                vld_p  = valid_q[km1];
            end
            rem_s = {rem_p[REM_W-3:0], rad_p[IN_W-1 -: 2]};
            trial = {root_p, 2'b01};
            if (rem_s >= trial) begin
                rem_d[k] = rem_s - trial;
                root_n   = (root_p << 1) | OUT_W'(1);
            end else begin
                rem_d[k] = rem_s;
                root_n   = root_p << 1;
            end
            // Last stage carries the presented root; rounding keeps the floor remainder.
            if ((k == OUT_W - 1) && (ROUND != 0) && (rem_d[k] > REM_W'(root_n)) && !(&root_n)) begin
                root_n = root_n + OUT_W'(1);
            end
            root_d[k]  = root_n;
            rad_d[k]   = rad_p << 2;
            tag_d[k]   = tag_p;
            valid_d[k] = vld_p;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q           <= '0;
            root_q[OUT_W-1]   <= '0;
            rem_q[OUT_W-1]    <= '0;
            tag_q[OUT_W-1]    <= '0;
        end else if (en) begin
            valid_q <= valid_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            rad_q   <= rad_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = valid_q[OUT_W-1];
    assign bus.out_root  = root_q[OUT_W-1];
    assign bus.out_rem   = rem_q[OUT_W-1][OUT_W:0];
    assign bus.out_tag   = tag_q[OUT_W-1];
    assign bus.busy      = |valid_q;

    // The final radicand is fully consumed and the remainder's top bit is always zero.
    logic unused_bits;
    assign unused_bits = ^{rad_q[OUT_W-1], rem_q[OUT_W-1][REM_W-1]};
endmodule

// File: tb/tb_pipe_sqrt_n.sv
// Scoreboard bench for pipe_sqrt_n: a floor-root and a rounding instance share one stimulus stream.
module tb_pipe_sqrt_n;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned OUT_W = 8;

    typedef struct {
        int unsigned root;
        int unsigned root_r;
        int unsigned rem;
        int unsigned tag;
        int unsigned en_at;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic [TAG_W-1:0] in_tag = '0;

    exp_t        q[$];
    exp_t        cur_exp;
    int unsigned vecs = 0;
    int unsigned miscmp = 0;
    int unsigned en_cnt = 0;
    logic        last_acc = 1'b0;
    logic        rand_ready = 1'b0;

    always #5 clk = ~clk;

    pipe_sqrt_n_if #(.IN_W(IN_W), .TAG_W(TAG_W)) bus0 ();
    pipe_sqrt_n_if #(.IN_W(IN_W), .TAG_W(TAG_W)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.in_tag    = in_tag;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.in_tag    = in_tag;
    assign bus1.out_ready = out_ready;

    pipe_sqrt_n #(.IN_W(IN_W), .ROUND(0), .TAG_W(TAG_W)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipe_sqrt_n #(.IN_W(IN_W), .ROUND(1), .TAG_W(TAG_W)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input int unsigned a, input int unsigned tag);
        exp_t        e;
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        e.root   = r;
        e.rem    = a - r * r;
        e.root_r = (e.rem > r && r != 255) ? r + 1 : r;
        e.tag    = tag;
        e.en_at  = 0;
        return e;
    endfunction

    // One clock: check presented state against the scoreboard, then advance it.
    task automatic cycle();
        logic exp_v, acc, cons, en;
        exp_t e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
        exp_v = 1'b0;
        if (q.size() > 0) exp_v = (en_cnt - q[0].en_at) >= OUT_W;
        chk("out_valid", bus0.out_valid, exp_v);
        chk("in_ready", bus0.in_ready, !exp_v || out_ready);
        chk("busy", bus0.busy, q.size() != 0);
        if (bus0.out_valid && q.size() > 0) begin
            chk("root", bus0.out_root, q[0].root);
            chk("root_round", bus1.out_root, q[0].root_r);
            chk("rem", bus0.out_rem, q[0].rem);
            chk("tag", bus0.out_tag, q[0].tag);
        end
        acc  = in_valid && bus0.in_ready;
        cons = bus0.out_valid && out_ready;
        en   = bus0.in_ready;
        if (cons && q.size() > 0) begin
            chk("latency", en_cnt - q[0].en_at, OUT_W);
            void'(q.pop_front());
        end
        if (acc) begin
            e       = cur_exp;
            e.en_at = en_cnt;
            q.push_back(e);
        end
        if (en) en_cnt++;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send_exp(input int unsigned a, input int unsigned tag, input exp_t e);
        int unsigned budget = 0;
        cur_exp  = e;
        in_valid = 1'b1;
        in_data  = IN_W'(a);
        in_tag   = TAG_W'(tag);
        do begin
            cycle();
            budget++;
        end while (!last_acc && budget < 200);
        if (!last_acc) chk("accept_timeout", last_acc, 1'b1);
    endtask

    task automatic send(input int unsigned a, input int unsigned tag);
        send_exp(a, tag, model(a, tag));
    endtask

    task automatic send_lit(input int unsigned a, input int unsigned tag, input int unsigned root,
                            input int unsigned root_r, input int unsigned rem);
        exp_t e;
        e.root   = root;
        e.root_r = root_r;
        e.rem    = rem;
        e.tag    = tag;
        e.en_at  = 0;
        send_exp(a, tag, e);
    endtask

    task automatic drain();
        int unsigned budget = 0;
        in_valid = 1'b0;
        while (q.size() > 0 && budget < 400) begin
            cycle();
            budget++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", bus0.out_valid, 1'b0);
        chk("rst_busy", bus0.busy, 1'b0);
        chk("rst_root", bus0.out_root, 0);
        chk("rst_root_round", bus1.out_root, 0);
        chk("rst_rem", bus0.out_rem, 0);
        chk("rst_tag", bus0.out_tag, 0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst       = 1'b1;
        out_ready = 1'b1;

        // Directed values, both floor and rounded roots.
        send_lit(0, 1, 0, 0, 0);
        send_lit(144, 2, 12, 12, 0);
        send_lit(156, 3, 12, 12, 12);
        send_lit(65535, 4, 255, 255, 510);
        send_lit(157, 5, 12, 13, 13);
        drain();
        send_lit(49, 6, 7, 7, 0);
        drain();

        // Back-to-back stream with tags from the low radicand bits.
        for (int a = 0; a < 1024; a++) send(a, a & 15);
        drain();

        // Random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) send($urandom_range(0, 65535), i & 15);
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Reset with samples in flight: none may emerge afterwards.
        for (int i = 0; i < 5; i++) send(1000 + i * 37, i);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_reset_state();
        q.delete();
        repeat (12) cycle();
        send_lit(49, 9, 7, 7, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule

// File: doc/pipe_sqrt_n.md
Name: pipe_sqrt_n

Overview:
Parametrised, fully pipelined unsigned integer square root with valid/ready flow control. Each stage resolves one result bit using the restoring digit-by-digit method. It is the general-width successor to the fixed 8-bit pipelined square-root core. It adds a remainder output, optional round-to-nearest, a tag passthrough and backpressure, and sits between streaming datapath blocks.

Parameters:
IN_W, 16, radicand width; must be even and at least 2.
OUT_W, IN_W/2, root width and pipeline depth; derived, not overridable.
ROUND, 0, 0 = floor root; 1 = root rounded to nearest, saturating at all-ones.
TAG_W, 4, width of the user tag carried alongside each sample; at least 1.

Ports:
clk  in  1  clock; all logic on its rising edge.
rst  in  1  synchronous, active-low reset.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample this cycle.
in_data  in  IN_W  unsigned radicand A.
in_tag  in  TAG_W  user tag, returned unchanged with the result.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_root  out  OUT_W  floor(sqrt(A)), or the rounded root when ROUND=1.
out_rem  out  OUT_W+1  A - floor(sqrt(A))^2, always relative to the floor root; range 0..2*floor root.
out_tag  out  TAG_W  tag of the sample being presented.
busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Clears all stage valid bits; out_valid=0, busy=0.
  - out_root, out_rem and out_tag become 0.
  - Data registers in inner stages need not be reset.
- Reset asserted mid-operation discards all in-flight samples. No result is emitted for them.
- Stages: stage k (k = 0..OUT_W-1) holds valid, partial root (k+1 bits), partial remainder (OUT_W+2 bits), the unconsumed radicand bits, and the tag.
- Per-stage step:
  - rem' = (rem<<2) | next two MSBs of A.
  - trial = (root<<2) | 1.
  - If rem' >= trial: rem = rem' - trial and root = (root<<1) | 1.
  - Otherwise: rem = rem' and root = root<<1.
- Stage 0 starts from root=0 and rem=0.
- The final stage register drives out_root, out_rem and out_tag directly; no combinational logic sits after it.
- ROUND=1:
  - In the last stage, if final rem > final root, out_root = root+1.
  - If root is all-ones, out_root stays all-ones (saturate).
  - out_rem is unaffected by rounding.
- Flow control uses one global enable: en = !out_valid | out_ready.
  - in_ready = en.
  - When en=1, every stage loads from its predecessor, including its valid bit.
  - When en=0, all stages hold.
- Input handshake:
  - A sample is accepted when in_valid & in_ready.
  - If in_valid=0 while en=1, a bubble (valid=0) enters stage 0.
- Output handshake:
  - A result is consumed when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_root, out_rem and out_tag are held stable.
- Latency: exactly OUT_W enabled cycles from input acceptance to out_valid.
- Throughput: 1 sample per cycle while out_ready=1. Samples are never dropped, duplicated or reordered.
- Simultaneous events:
  - Acceptance and consumption in the same cycle are both honoured.
  - rst=0 overrides everything.
- in_data and in_tag are don't-care when in_valid=0.
- busy=1 iff any stage holds a valid sample; it stays 1 while the pipeline is stalled.

Test Plan:
1. IN_W=16, ROUND=0: A=0, 144, 156, 65535 -> root/rem 0/0, 12/0, 12/12, 255/510. Each appears 8 cycles after acceptance with out_ready=1.
2. ROUND=1: A=156 -> root 12. A=157 -> root 13, rem 13. A=65535 -> root 255 (saturated), rem 510.
3. Stream A=0..1023 back-to-back with tags = A[3:0] and out_ready=1 -> one result per cycle. In-order; tags match; root/rem match a reference model.
4. Backpressure: stream 20 samples while toggling out_ready pseudo-randomly -> in_ready == (!out_valid | out_ready) every cycle. Outputs stable while stalled; all 20 results are correct, in order, with none lost.
5. Reset mid-operation: accept 5 samples, then drive rst=0 for 1 cycle. Next cycle: out_valid=0, busy=0, outputs 0, and none of the 5 results is ever emitted. A new sample A=49 then yields root 7, rem 0 after 8 cycles.
6. IN_W=8 and IN_W=32 builds: exhaustive test (8-bit) and random 10k samples (32-bit) against a floor-sqrt model; latencies of 4 and 16 cycles respectively.
